// File: rtl/ddr3_pkg.sv
// Shared types for the DDR3 frame master: FSM encoding, sample width, index sizing.
// No logic; latency and backpressure are defined by the modules that import it.
package ddr3_pkg;

  localparam int SAMPLE_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // Index counter width; a one-sample frame still needs a 1-bit counter.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with show-ahead head; pop_data is valid in the same cycle as !empty.
// Push while full is dropped unless a pop happens in the same cycle; the writer must respect count.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             full, do_push, do_pop;

  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ddr3_frame_master.sv
// Streams one frame of samples into DDR, then reads it back in order; write command one cycle after in handshake.
// ddr_waitrequest holds command/address/data; reads throttle so outstanding reads plus buffered words stay within RD_DEPTH.
module ddr3_frame_master
  import ddr3_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'd0,
  parameter int          FRAME_LEN = 256,
  parameter int          RD_DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic signed [SAMPLE_W-1:0] in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic signed [SAMPLE_W-1:0] out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic                       frame_done,
  output logic                       busy,
  output logic [31:0]                ddr_addr,
  output logic                       ddr_read,
  output logic                       ddr_write,
  output logic signed [SAMPLE_W-1:0] ddr_writedata,
  input  logic                       ddr_waitrequest,
  input  logic signed [SAMPLE_W-1:0] ddr_readdata,
  input  logic                       ddr_readdatavalid
);

  localparam int            IW        = idx_w(FRAME_LEN);
  localparam int            CW        = $clog2(RD_DEPTH + 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(FRAME_LEN - 1);
  localparam logic [CW:0]   DEPTH_LIM = (CW + 1)'(RD_DEPTH);

  function automatic logic [IW-1:0] bump(input logic [IW-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + IW'(1);
  endfunction

  state_t        state, state_nxt;
  logic [IW-1:0] wr_idx, rd_idx, out_idx;
  logic [31:0]   wr_addr;
  logic [CW-1:0] pending, fifo_count;
  logic          wr_final;
  logic          in_hs, wr_acc, rd_acc, fifo_push, fifo_pop, fifo_empty, last_hs;

  assign busy      = (state != ST_IDLE);
  assign in_ready  = (state == ST_WRITE) && !wr_final && (!ddr_write || !ddr_waitrequest);
  assign in_hs     = in_valid && in_ready;
  assign wr_acc    = ddr_write && !ddr_waitrequest;
  // Occupancy only shrinks while a read waits, so this combinational command stays stable under stall.
  assign ddr_read  = (state == ST_READ) && (({1'b0, pending} + {1'b0, fifo_count}) < DEPTH_LIM);
  assign rd_acc    = ddr_read && !ddr_waitrequest;
  assign ddr_addr  = (state == ST_READ) ? BASE_ADDR + 32'(rd_idx) : wr_addr;
  assign fifo_push = ddr_readdatavalid && ((state == ST_READ) || (state == ST_DRAIN));
  assign out_valid = !fifo_empty;
  assign fifo_pop  = out_valid && out_ready;
  assign out_last  = out_valid && (out_idx == LAST_IDX);
  assign last_hs   = fifo_pop && out_last;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (enable) state_nxt = ST_WRITE;
      ST_WRITE: if (wr_acc && wr_final) state_nxt = ST_READ;
      ST_READ:  if (rd_acc && (rd_idx == LAST_IDX)) state_nxt = ST_DRAIN;
      ST_DRAIN: if (last_hs) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      wr_idx        <= '0;
      rd_idx        <= '0;
      out_idx       <= '0;
      wr_addr       <= '0;
      wr_final      <= 1'b0;
      pending       <= '0;
      ddr_write     <= 1'b0;
      ddr_writedata <= '0;
      frame_done    <= 1'b0;
    end else begin
      state      <= state_nxt;
      frame_done <= last_hs;
      // wr_final marks the last sample sitting in the write register until DDR takes it.
      if (in_hs) begin
        ddr_write     <= 1'b1;
        ddr_writedata <= in_data;
        wr_addr       <= BASE_ADDR + 32'(wr_idx);
        wr_idx        <= bump(wr_idx);
        if (wr_idx == LAST_IDX) wr_final <= 1'b1;
      end else if (wr_acc) begin
        ddr_write <= 1'b0;
        wr_final  <= 1'b0;
      end
      if (rd_acc)   rd_idx  <= bump(rd_idx);
      if (fifo_pop) out_idx <= bump(out_idx);
      if (rd_acc && !fifo_push)      pending <= pending + CW'(1);
      else if (!rd_acc && fifo_push) pending <= pending - CW'(1);
    end
  end

  sync_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (RD_DEPTH)
  ) u_rd_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .push_data (ddr_readdata),
    .pop       (fifo_pop),
    .pop_data  (out_data),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: doc/ddr3_frame_master.md
DDR3_FRAME_MASTER -- requirements
Module: ddr3_frame_master

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 0, meaning the first DDR word address of the frame buffer.
REQ-002 SHALL have parameter FRAME_LEN, default 256, meaning the number of samples per frame (range 2..65536).
REQ-003 SHALL have parameter RD_DEPTH, default 4, meaning the maximum number of outstanding reads plus buffered readback words.
REQ-004 SHALL have ports, in this order:
- clk  in  1  sole clock, rising edge
- reset_n  in  1  synchronous active-low reset
- enable  in  1  permits IDLE->WRITE
- in_data  in  16  signed sample to store
- in_valid  in  1  in_data present
- in_ready  out  1  sample accepted when in_valid&in_ready
- out_data  out  16  signed sample read back
- out_valid  out  1  out_data present
- out_ready  in  1  sink accepts when out_valid&out_ready
- out_last  out  1  marks sample FRAME_LEN-1 of the frame
- frame_done  out  1  one-cycle pulse at frame end
- busy  out  1  high whenever state != IDLE
- ddr_addr  out  32  word address
- ddr_read  out  1  read command
- ddr_write  out  1  write command
- ddr_writedata  out  16  signed write data
- ddr_waitrequest  in  1  responder stall
- ddr_readdata  in  16  signed read data
- ddr_readdatavalid  in  1  ddr_readdata valid this cycle
REQ-005 SHALL use one clock; reset is synchronous and active-low.

Function
REQ-006 SHALL implement FSM states IDLE, WRITE, READ, DRAIN.
REQ-007 SHALL: IDLE->WRITE when enable=1; WRITE->READ on write acceptance of index FRAME_LEN-1; READ->DRAIN on read acceptance of index FRAME_LEN-1; DRAIN->IDLE on output handshake of out_last, pulsing frame_done in the following cycle.
REQ-008 SHALL treat a DDR command as accepted on a rising edge where the command is high and ddr_waitrequest=0; ddr_addr, ddr_writedata and the command SHALL be held stable while ddr_waitrequest=1.
REQ-009 SHALL never assert ddr_read and ddr_write in the same cycle.
REQ-010 In WRITE, SHALL assert in_ready = (ddr_write==0) | (ddr_waitrequest==0); on an in handshake it SHALL register ddr_write=1, ddr_writedata=in_data, ddr_addr=BASE_ADDR+wr_idx in the next cycle; back-to-back samples SHALL sustain one write per cycle with no stall.
REQ-011 SHALL drop ddr_write the cycle after the final accepted write, unless a new sample is simultaneously accepted (impossible at index FRAME_LEN-1, so ddr_write=0 on entering READ).
REQ-012 In READ, SHALL issue reads to ddr_addr=BASE_ADDR+rd_idx only while pending+fifo_count < RD_DEPTH, pending counting accepted reads without readdatavalid.
REQ-013 Each ddr_readdatavalid SHALL push ddr_readdata into the readback FIFO (same cycle as a pop allowed); readdatavalid in IDLE or WRITE SHALL be ignored.
REQ-014 out_valid SHALL equal FIFO non-empty; out_last SHALL be high exactly with the FRAME_LEN-th output sample.
REQ-015 Index counters SHALL be ceil(log2(FRAME_LEN)) bits and clear to 0 at frame end; address arithmetic SHALL be 32-bit unsigned, wrapping modulo 2^32.
REQ-016 enable deasserted mid-frame SHALL NOT abort the frame; it only gates the next IDLE->WRITE.
REQ-017 Samples SHALL be returned in write order, bit-exact.

Reset
REQ-018 While reset_n=0 at a clock edge: state=IDLE, all counters=0, FIFO empty; in_ready, out_valid, out_last, frame_done, busy, ddr_read, ddr_write=0; ddr_addr, ddr_writedata, out_data=0.
REQ-019 Reset mid-frame SHALL abandon the frame immediately; late ddr_readdatavalid after reset SHALL be ignored.

Structure
REQ-020 FSM state encoding and the 16-bit sample width constant SHALL live in the shared package ddr3_pkg.
REQ-021 The readback FIFO SHALL be one sub-module, sync_fifo (parameters WIDTH=16, DEPTH=RD_DEPTH).

Verification
REQ-022 FRAME_LEN=8, inputs 1..8 back-to-back, no waitrequest -> writes to addr 0..7 on 8 consecutive cycles, outputs 1..8, out_last on 8, frame_done once.
REQ-023 waitrequest=1 for 10 cycles on the write to addr 5 -> addr/data held at 5/6 for the stall, in_ready=0, no sample lost, output 1..8.
REQ-024 out_ready=0 during READ -> exactly RD_DEPTH=4 reads issued, then ddr_read stays 0 until out_ready=1.
REQ-025 Inputs -32768, 32767, -1 -> identical signed values returned; ddr_read & ddr_write never high together (assertion).
REQ-026 reset_n=0 for one cycle after 3 writes -> all outputs 0, state IDLE; next frame starts at BASE_ADDR.
